// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus host arbiter: host count limit and the
// width rule used for host index signals.
package bus_arb_pkg;

    // Largest number of hosts the arbiter is built for.
    localparam int MAX_HOSTS = 8;

    // Index type wide enough for any supported host count.
    typedef logic [$clog2(MAX_HOSTS)-1:0] host_idx_max_t;

    // Width of a host index for a given host count (at least one bit).
    function automatic int host_idx_w(input int nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

endpackage

// File: rtl/arb_idx_fifo.sv
// Small synchronous FIFO holding the issuing host index of each accepted
// transaction so responses can be routed back in order.
module arb_idx_fifo
    import bus_arb_pkg::*;
#(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state for pointers and occupancy; simultaneous push/pop keeps count.
    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device bus port among several hosts using
// the req/gnt/rvalid protocol, with in-order response routing.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrHosts-1:0]             host_req_i,
    input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]             host_we_i,
    input  logic [NrHosts*4-1:0]           host_be_i,
    input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]             host_gnt_o,
    output logic [NrHosts-1:0]             host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]   host_rdata_o,
    output logic [NrHosts-1:0]             host_err_o,
    output logic                           dev_req_o,
    output logic [AddrWidth-1:0]           dev_addr_o,
    output logic                           dev_we_o,
    output logic [3:0]                     dev_be_o,
    output logic [DataWidth-1:0]           dev_wdata_o,
    input  logic                           dev_gnt_i,
    input  logic                           dev_rvalid_i,
    input  logic [DataWidth-1:0]           dev_rdata_i,
    input  logic                           dev_err_i
);

    localparam int IdxW = host_idx_w(NrHosts);
    typedef logic [IdxW-1:0] host_idx_t;

    host_idx_t rr_ptr_q, rr_ptr_d;
    logic      lock_q, lock_d;
    host_idx_t lock_idx_q, lock_idx_d;

    logic      win_vld;
    host_idx_t win_idx;
    logic      handshake;
    logic      pop;
    logic      fifo_full, fifo_empty;
    host_idx_t fifo_head;

    // First requesting host at or after 'start', wrapping modulo NrHosts.
    // Result is {found, index}.
    function automatic logic [IdxW:0] rr_select(input logic [NrHosts-1:0] req,
                                                input host_idx_t start);
        logic      found;
        host_idx_t idx;
        int        c;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NrHosts; i++) begin
            c = int'(start) + i;
            if (c >= NrHosts) c = c - NrHosts;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = host_idx_t'(c);
            end
        end
        return {found, idx};
    endfunction

    // Winner selection: a stalled request keeps the bus until accepted.
    always_comb begin
        logic [IdxW:0] sel;
        sel = rr_select(host_req_i, rr_ptr_q);
        if (lock_q) begin
            win_vld = 1'b1;
            win_idx = lock_idx_q;
        end else begin
            win_vld = sel[IdxW];
            win_idx = sel[IdxW-1:0];
        end
    end

    // A full response FIFO blocks issue even if a response pops this cycle.
    assign dev_req_o = win_vld & ~fifo_full & ~rst_i;
    assign handshake = dev_req_o & dev_gnt_i;

    // Forward the winner's payload and return the grant to it alone.
    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        host_gnt_o  = '0;
        for (int i = 0; i < NrHosts; i++) begin
            if (win_idx == host_idx_t'(i)) begin
                dev_addr_o    = host_addr_i[i*AddrWidth +: AddrWidth];
                dev_we_o      = host_we_i[i];
                dev_be_o      = host_be_i[i*4 +: 4];
                dev_wdata_o   = host_wdata_i[i*DataWidth +: DataWidth];
                host_gnt_o[i] = handshake;
            end
        end
    end

    // Responses with nothing outstanding (or during reset) are dropped.
    assign pop = dev_rvalid_i & ~fifo_empty & ~rst_i;

    // Route the response to the host at the FIFO head; data goes to everyone.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int i = 0; i < NrHosts; i++) begin
            if (fifo_head == host_idx_t'(i)) begin
                host_rvalid_o[i] = pop;
                host_err_o[i]    = pop & dev_err_i;
            end
        end
    end

    assign host_rdata_o = {NrHosts{dev_rdata_i}};

    // Pointer advance on acceptance, lock capture on a stalled request.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (handshake) begin
            rr_ptr_d = (win_idx == host_idx_t'(NrHosts - 1)) ? '0 : win_idx + 1'b1;
            lock_d   = 1'b0;
        end else if (dev_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = win_idx;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    arb_idx_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .pop_i   (pop),
        .wdata_i (win_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

`ifndef SYNTHESIS
    // Flag device responses that arrive with no transaction outstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_i && dev_rvalid_i) begin
            assert (!fifo_empty)
            else $warning("bus_host_arbiter: device response with nothing outstanding dropped");
        end
    end
`endif

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed testbench for bus_host_arbiter (2 hosts, 2 outstanding).
module tb_bus_host_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  host_req_i;
    logic [63:0] host_addr_i;
    logic [1:0]  host_we_i;
    logic [7:0]  host_be_i;
    logic [63:0] host_wdata_i;
    logic [1:0]  host_gnt_o;
    logic [1:0]  host_rvalid_o;
    logic [63:0] host_rdata_o;
    logic [1:0]  host_err_o;
    logic        dev_req_o;
    logic [31:0] dev_addr_o;
    logic        dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_wdata_o;
    logic        dev_gnt_i;
    logic        dev_rvalid_i;
    logic [31:0] dev_rdata_i;
    logic        dev_err_i;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    bus_host_arbiter #(
        .NrHosts        (2),
        .DataWidth      (32),
        .AddrWidth      (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .host_req_i    (host_req_i),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_wdata_i  (host_wdata_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_addr_o    (dev_addr_o),
        .dev_we_o      (dev_we_o),
        .dev_be_o      (dev_be_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_gnt_i     (dev_gnt_i),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_rdata_i   (dev_rdata_i),
        .dev_err_i     (dev_err_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst_i        = 1'b1;
        host_req_i   = 2'b11;
        host_addr_i  = {32'h0000_0200, 32'h0000_0100};
        host_we_i    = 2'b10;
        host_be_i    = 8'h3F;
        host_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
        dev_gnt_i    = 1'b1;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h0;
        dev_err_i    = 1'b1;

        // Reset: outputs forced low even with requests and responses present.
        tick(); settle();
        chk("rst_dev_req", 64'(dev_req_o), 64'h0);
        chk("rst_gnt", 64'(host_gnt_o), 64'h0);
        chk("rst_rvalid", 64'(host_rvalid_o), 64'h0);
        chk("rst_err", 64'(host_err_o), 64'h0);
        tick();
        chk("rst_count", 64'(dut.u_idx_fifo.count_q), 64'h0);

        // Fairness: alternating grants, responses one cycle later.
        rst_i = 1'b0; dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
        settle();
        chk("fair_g0", 64'(host_gnt_o), 64'h1);
        chk("fair_addr0", 64'(dev_addr_o), 64'h100);
        chk("fair_wdata0", 64'(dev_wdata_o), 64'hAAAA_0000);
        chk("fair_be0", 64'(dev_be_o), 64'hF);
        chk("fair_we0", 64'(dev_we_o), 64'h0);
        tick();
        for (int k = 1; k < 4; k++) begin
            dev_rvalid_i = 1'b1;
            dev_rdata_i  = 32'hD000_0000 + 32'(k);
            settle();
            chk($sformatf("fair_g%0d", k), 64'(host_gnt_o), (k % 2 == 1) ? 64'h2 : 64'h1);
            chk($sformatf("fair_rv%0d", k), 64'(host_rvalid_o), (k % 2 == 1) ? 64'h1 : 64'h2);
            chk($sformatf("fair_rdata%0d", k), host_rdata_o,
                {32'hD000_0000 + 32'(k), 32'hD000_0000 + 32'(k)});
            if (k == 1) begin
                chk("fair_addr1", 64'(dev_addr_o), 64'h200);
                chk("fair_we1", 64'(dev_we_o), 64'h1);
                chk("fair_be1", 64'(dev_be_o), 64'h3);
            end
            tick();
        end
        host_req_i = 2'b00;
        settle();
        chk("fair_last_rv", 64'(host_rvalid_o), 64'h2);
        chk("fair_idle_req", 64'(dev_req_o), 64'h0);
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        chk("fair_count", 64'(dut.u_idx_fifo.count_q), 64'h0);

        // Lock on stall: h1 waits while h0 joins; rr_ptr is 0 here.
        host_addr_i = {32'h0000_0204, 32'h0000_0104};
        dev_gnt_i   = 1'b0;
        host_req_i  = 2'b10;
        settle();
        chk("lock_req", 64'(dev_req_o), 64'h1);
        chk("lock_addr_c1", 64'(dev_addr_o), 64'h204);
        chk("lock_gnt_c1", 64'(host_gnt_o), 64'h0);
        tick();
        host_req_i = 2'b11;
        settle();
        chk("lock_addr_c2", 64'(dev_addr_o), 64'h204);
        chk("lock_gnt_c2", 64'(host_gnt_o), 64'h0);
        tick(); settle();
        chk("lock_addr_c3", 64'(dev_addr_o), 64'h204);
        tick();
        dev_gnt_i = 1'b1;
        settle();
        chk("lock_gnt_h1", 64'(host_gnt_o), 64'h2);
        chk("lock_addr_gnt", 64'(dev_addr_o), 64'h204);
        tick();
        host_req_i = 2'b01; dev_rvalid_i = 1'b1;
        settle();
        chk("lock_next_h0", 64'(host_gnt_o), 64'h1);
        chk("lock_addr_h0", 64'(dev_addr_o), 64'h104);
        chk("lock_rv_h1", 64'(host_rvalid_o), 64'h2);
        tick();
        host_req_i = 2'b00;
        settle();
        chk("lock_rv_h0", 64'(host_rvalid_o), 64'h1);
        tick();
        dev_rvalid_i = 1'b0;

        // FIFO full: rr_ptr is 1, device withholds responses.
        host_req_i = 2'b11;
        settle();
        chk("full_g1", 64'(host_gnt_o), 64'h2);
        tick(); settle();
        chk("full_g2", 64'(host_gnt_o), 64'h1);
        tick(); settle();
        chk("full_noreq", 64'(dev_req_o), 64'h0);
        chk("full_nognt", 64'(host_gnt_o), 64'h0);
        chk("full_count", 64'(dut.u_idx_fifo.count_q), 64'h2);
        tick();
        dev_rvalid_i = 1'b1;
        settle();
        chk("full_pop_rv", 64'(host_rvalid_o), 64'h2);
        chk("full_pop_noreq", 64'(dev_req_o), 64'h0);
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        chk("full_regrant", 64'(host_gnt_o), 64'h2);
        tick();
        host_req_i = 2'b00; dev_rvalid_i = 1'b1;
        settle();
        chk("full_drain0", 64'(host_rvalid_o), 64'h1);
        tick(); settle();
        chk("full_drain1", 64'(host_rvalid_o), 64'h2);
        tick();
        dev_rvalid_i = 1'b0;

        // Error routing: error without rvalid is invisible, then an h1 error response.
        dev_err_i  = 1'b1;
        host_req_i = 2'b10;
        settle();
        chk("err_unqual", 64'(host_err_o), 64'h0);
        chk("err_gnt_h1", 64'(host_gnt_o), 64'h2);
        tick();
        host_req_i = 2'b00; dev_rvalid_i = 1'b1;
        settle();
        chk("err_rv", 64'(host_rvalid_o), 64'h2);
        chk("err_err", 64'(host_err_o), 64'h2);
        tick();
        dev_rvalid_i = 1'b0; dev_err_i = 1'b0;

        // Spurious response with nothing outstanding.
        settle();
        chk("spur_count0", 64'(dut.u_idx_fifo.count_q), 64'h0);
        dev_rvalid_i = 1'b1; dev_err_i = 1'b1;
        settle();
        chk("spur_rv", 64'(host_rvalid_o), 64'h0);
        chk("spur_err", 64'(host_err_o), 64'h0);
        tick();
        dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
        settle();
        chk("spur_count", 64'(dut.u_idx_fifo.count_q), 64'h0);

        // Reset with two outstanding; rr_ptr is 0 before this.
        host_req_i = 2'b11;
        tick(); tick();
        chk("rmo_count2", 64'(dut.u_idx_fifo.count_q), 64'h2);
        host_req_i = 2'b10;
        rst_i = 1'b1; dev_rvalid_i = 1'b1;
        settle();
        chk("rmo_req", 64'(dev_req_o), 64'h0);
        chk("rmo_gnt", 64'(host_gnt_o), 64'h0);
        chk("rmo_rv", 64'(host_rvalid_o), 64'h0);
        tick();
        rst_i = 1'b0; host_req_i = 2'b00;
        settle();
        chk("rmo_late_rv", 64'(host_rvalid_o), 64'h0);
        chk("rmo_count0", 64'(dut.u_idx_fifo.count_q), 64'h0);
        tick();
        dev_rvalid_i = 1'b0;
        host_req_i = 2'b11;
        settle();
        chk("rmo_first_h0", 64'(host_gnt_o), 64'h1);
        tick();
        host_req_i = 2'b00; dev_rvalid_i = 1'b1;
        settle();
        chk("rmo_rv_h0", 64'(host_rvalid_o), 64'h1);
        tick();
        dev_rvalid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
